aes_ctr_stream: RTL and testbench

- Drives the AES-256 core's counter-block input and consumes its keystream output to form the AES-256-CTR datapath.
- Acts as the AXI-stream transmitter into the core's s_axis slave.
- Buffers returning keystream (po_data/po_data_valid, which has no backpressure) in a credit-protected FIFO.
- XORs each buffered keystream block with the payload stream and emits the result on an AXI-stream master.

---
 rtl/aes_ctr_pkg.sv | 19 +
 rtl/ks_fifo.sv | 69 ++++++
 rtl/aes_ctr_stream.sv | 206 ++++++++++++++++++++
 tb/tb_aes_ctr_stream.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_pkg.sv
`default_nettype none
// ============================================================================
// aes_ctr_pkg : shared types for the AES-256-CTR stream datapath
// Rev 1.0
// ============================================================================
package aes_ctr_pkg;

  localparam int AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctr_state_t;

endpackage
`default_nettype wire

// File: rtl/ks_fifo.sv
`default_nettype none
// ============================================================================
// ks_fifo : synchronous keystream FIFO; a push into an empty FIFO with a
//           simultaneous pop passes straight through to o_head.
// Rev 1.0
// ============================================================================
module ks_fifo
  import aes_ctr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  aes_blk_t i_data,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_empty,
  output logic     o_avail,
  output aes_blk_t o_head
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  aes_blk_t             r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 w_wr;
  logic                 w_rd;

  assign o_full  = (r_count == c_CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_avail = !o_empty || i_push;
  assign o_head  = o_empty ? i_data : r_mem[r_rd_ptr];

  // Full+pop frees a slot for the push; empty+pop consumes the push directly.
  assign w_wr = i_push && (!o_full || i_pop) && !(o_empty && i_pop);
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_wr && w_rd) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_ctr_stream.sv
`default_nettype none
// ============================================================================
// aes_ctr_stream : AES-256-CTR datapath around an external AES core; issues
//                  counter blocks, buffers keystream, XORs with payload.
//                  Optional wrap guard: AES_CTR_WRAP_GUARD_EN
// Rev 1.0
// ============================================================================
module aes_ctr_stream
  import aes_ctr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CTR_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     pi_start,
  input  aes_blk_t pi_iv,
  input  logic     pi_key_ready,
  output logic     m_core_tvalid,
  input  logic     m_core_tready,
  output aes_blk_t m_core_tdata,
  input  logic     pi_ks_valid,
  input  aes_blk_t pi_ks_data,
  input  logic     s_axis_tvalid,
  output logic     s_axis_tready,
  input  aes_blk_t s_axis_tdata,
  input  logic     s_axis_tlast,
  output logic     m_axis_tvalid,
  input  logic     m_axis_tready,
  output aes_blk_t m_axis_tdata,
  output logic     m_axis_tlast,
  output logic     po_busy,
  output logic     po_ks_overflow
`ifdef AES_CTR_WRAP_GUARD_EN
  ,
  output logic     po_ctr_wrap
`endif
);

  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  ctr_state_t          r_state;
  ctr_state_t          w_state_next;
  aes_blk_t            r_ctr;
  aes_blk_t            w_ctr_inc;
  logic [CTR_W-1:0]    w_ctr_lo;
  logic                r_core_valid;
  logic [c_CNT_W-1:0]  r_outstanding;
  logic [c_CNT_W-1:0]  w_outstanding_next;
  logic                r_m_valid;
  logic                r_m_last;
  aes_blk_t            r_m_data;
  logic                r_overflow;
  logic                w_start;
  logic                w_core_hs;
  logic                w_s_ready;
  logic                w_accept;
  logic                w_pop;
  logic                w_issue_ok;
  logic                w_wrap_block;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_fifo_avail;
  aes_blk_t            w_fifo_head;

  ks_fifo #(.DEPTH(DEPTH)) u_ks_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (pi_ks_valid),
    .i_data  (pi_ks_data),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_avail (w_fifo_avail),
    .o_head  (w_fifo_head)
  );

  assign w_start   = (r_state == IDLE) && pi_start;
  assign w_core_hs = r_core_valid && m_core_tready;
  assign w_ctr_lo  = r_ctr[CTR_W-1:0] + CTR_W'(1);

  generate
    if (CTR_W == AES_BLK_W) begin : g_ctr_full
      assign w_ctr_inc = w_ctr_lo;
    end else begin : g_ctr_part
      assign w_ctr_inc = {r_ctr[AES_BLK_W-1:CTR_W], w_ctr_lo};
    end
  endgenerate

`ifdef AES_CTR_WRAP_GUARD_EN
  logic r_ctr_wrap;
  logic w_wrap_hit;

  assign w_wrap_hit   = w_core_hs && (&r_ctr[CTR_W-1:0]);
  // A new message clears the flag on the same edge, so it must not block its first issue.
  assign w_wrap_block = w_wrap_hit || (r_ctr_wrap && !w_start);
  assign po_ctr_wrap  = r_ctr_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr_wrap <= 1'b0;
    end else if (w_start) begin
      r_ctr_wrap <= 1'b0;
    end else if (w_wrap_hit) begin
      r_ctr_wrap <= 1'b1;
    end
  end
`else
  assign w_wrap_block = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_ready    = 1'b0;
    w_accept     = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (pi_start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_s_ready = w_fifo_avail && (!r_m_valid || m_axis_tready);
        w_accept  = w_s_ready && s_axis_tvalid;
        w_pop     = w_accept;
        if (w_accept && s_axis_tlast) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_pop = w_fifo_avail;
        // A presented-but-unaccepted block would still return keystream later.
        if ((r_outstanding == '0) && w_fifo_empty && !r_core_valid) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_core_hs && !w_pop) begin
      w_outstanding_next = r_outstanding + c_CNT_W'(1);
    end else if (!w_core_hs && w_pop) begin
      w_outstanding_next = r_outstanding - c_CNT_W'(1);
    end
  end

  assign w_issue_ok = (w_state_next == RUN) && pi_key_ready && !w_wrap_block &&
                      (w_outstanding_next < c_CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr         <= '0;
      r_core_valid  <= 1'b0;
      r_outstanding <= '0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
      r_m_data      <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_start) begin
        r_ctr <= pi_iv;
      end else if (w_core_hs) begin
        r_ctr <= w_ctr_inc;
      end
      if (!r_core_valid || m_core_tready) begin
        r_core_valid <= w_issue_ok;
      end
      r_outstanding <= w_outstanding_next;
      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= s_axis_tdata ^ w_fifo_head;
        r_m_last  <= s_axis_tlast;
      end else if (m_axis_tready) begin
        r_m_valid <= 1'b0;
      end
      if (pi_ks_valid && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign m_core_tvalid  = r_core_valid;
  assign m_core_tdata   = r_ctr;
  assign s_axis_tready  = w_s_ready;
  assign m_axis_tvalid  = r_m_valid;
  assign m_axis_tdata   = r_m_data;
  assign m_axis_tlast   = r_m_last;
  assign po_busy        = (r_state != IDLE);
  assign po_ks_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_aes_ctr_stream.sv
`default_nettype none
// ============================================================================
// tb_aes_ctr_stream : scoreboard bench with a behavioural AES-core stand-in
// Rev 1.0
// ============================================================================
module tb_aes_ctr_stream;
  import aes_ctr_pkg::*;

  localparam int DEPTH = 4;
  localparam int CTR_W = 32;
  localparam int LAT   = 3;

  localparam aes_blk_t NIST_IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam aes_blk_t NIST_CTR1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam aes_blk_t NIST_P0   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam aes_blk_t NIST_P1   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam aes_blk_t NIST_C0   = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam aes_blk_t NIST_C1   = 128'hf443e3ca4d62b59aca84e990cacaf5c5;

  logic     clk = 1'b0;
  logic     rst;
  logic     pi_start;
  aes_blk_t pi_iv;
  logic     pi_key_ready;
  logic     m_core_tvalid;
  logic     m_core_tready;
  aes_blk_t m_core_tdata;
  logic     pi_ks_valid;
  aes_blk_t pi_ks_data;
  logic     s_axis_tvalid;
  logic     s_axis_tready;
  aes_blk_t s_axis_tdata;
  logic     s_axis_tlast;
  logic     m_axis_tvalid;
  logic     m_axis_tready;
  aes_blk_t m_axis_tdata;
  logic     m_axis_tlast;
  logic     po_busy;
  logic     po_ks_overflow;
`ifdef AES_CTR_WRAP_GUARD_EN
  logic     po_ctr_wrap;
`endif

  always #5 clk = ~clk;

  aes_ctr_stream #(.DEPTH(DEPTH), .CTR_W(CTR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pi_start       (pi_start),
    .pi_iv          (pi_iv),
    .pi_key_ready   (pi_key_ready),
    .m_core_tvalid  (m_core_tvalid),
    .m_core_tready  (m_core_tready),
    .m_core_tdata   (m_core_tdata),
    .pi_ks_valid    (pi_ks_valid),
    .pi_ks_data     (pi_ks_data),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .po_busy        (po_busy),
    .po_ks_overflow (po_ks_overflow)
`ifdef AES_CTR_WRAP_GUARD_EN
    ,
    .po_ctr_wrap    (po_ctr_wrap)
`endif
  );

  typedef struct {aes_blk_t d; logic l;} exp_t;
  typedef struct {aes_blk_t c; int due;} fl_t;

  exp_t     sb[$];
  aes_blk_t ctr_log[$];
  int       hs_count = 0;
  int       out_count = 0;
  int       vectors = 0;
  int       miscompares = 0;
  int       core_rdy_mode = 0;
  int       key_rdy_mode = 0;
  int       mrdy_mode = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stand-in for AES-256: NIST keystream for the two reference counters, a fixed mix otherwise.
  function automatic aes_blk_t ks_fn(input aes_blk_t c);
    if (c == NIST_IV)   return NIST_P0 ^ NIST_C0;
    if (c == NIST_CTR1) return NIST_P1 ^ NIST_C1;
    return {c[63:0] ^ 64'h9e3779b97f4a7c15, c[127:64] + 64'hc2b2ae3d27d4eb4f};
  endfunction

  function automatic aes_blk_t ctr_at(input aes_blk_t iv, input int i);
    aes_blk_t r = iv;
    r[CTR_W-1:0] = iv[CTR_W-1:0] + CTR_W'(i);
    return r;
  endfunction

  function automatic aes_blk_t rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Core model: fixed-latency, in-order keystream for every accepted counter block.
  initial begin : core_model
    fl_t      fl[$];
    logic     hs;
    logic     r;
    aes_blk_t c;
    int       cyc = 0;
    pi_ks_valid   = 1'b0;
    pi_ks_data    = '0;
    m_core_tready = 1'b1;
    pi_key_ready  = 1'b1;
    forever begin
      @(negedge clk);
      r  = rst;
      hs = m_core_tvalid && m_core_tready && !rst;
      c  = m_core_tdata;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
        fl.delete();
      end else if (hs) begin
        fl.push_back('{c, cyc + LAT});
        ctr_log.push_back(c);
        hs_count++;
      end
      if (!r && fl.size() > 0 && fl[0].due <= cyc) begin
        pi_ks_valid = 1'b1;
        pi_ks_data  = ks_fn(fl[0].c);
        fl.delete(0);
      end else begin
        pi_ks_valid = 1'b0;
        pi_ks_data  = '0;
      end
      m_core_tready = (core_rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      pi_key_ready  = (key_rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin : out_ready_drv
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mrdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    exp_t     e;
    logic     stall_prev = 1'b0;
    aes_blk_t hold_d = '0;
    logic     hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) begin
        check("hold_valid", 128'(m_axis_tvalid), 128'(1));
        check("hold_data", m_axis_tdata, hold_d);
        check("hold_last", 128'(m_axis_tlast), 128'(hold_l));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got %h with no block outstanding", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          check("out_data", m_axis_tdata, e.d);
          check("out_last", 128'(m_axis_tlast), 128'(e.l));
          out_count++;
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_d     = m_axis_tdata;
      hold_l     = m_axis_tlast;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic start_msg(input aes_blk_t iv);
    ctr_log.delete();
    hs_count = 0;
    pi_iv    = iv;
    pi_start = 1'b1;
    @(posedge clk);
    #1;
    pi_start = 1'b0;
  endtask

  task automatic send_blk(input aes_blk_t d, input logic l, input aes_blk_t e, input int gap_max);
    int t = 0;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    forever begin
      @(negedge clk);
      if (s_axis_tready) begin
        sb.push_back('{e, l});
        @(posedge clk);
        #1;
        break;
      end
      if (++t > 300) begin
        check("accept_timeout", 128'(s_axis_tready), 128'(1));
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(nm, 128'(sb.size()), 128'(0));
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (po_busy && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(nm, 128'(po_busy), 128'(0));
  endtask

  task automatic run_msg(input string nm, input aes_blk_t iv, input int n, input int gap_max);
    aes_blk_t d;
    int       o0 = out_count;
    start_msg(iv);
    for (int i = 0; i < n; i++) begin
      d = rand128();
      send_blk(d, 1'(i == n - 1), d ^ ks_fn(ctr_at(iv, i)), gap_max);
    end
    wait_drain({nm, "_drain"});
    wait_idle({nm, "_idle"});
    check({nm, "_count"}, 128'(out_count - o0), 128'(n));
    check({nm, "_ctr0"}, (ctr_log.size() > 0) ? ctr_log[0] : 'x, iv);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_core_tvalid"}, 128'(m_core_tvalid), 128'(0));
    check({nm, "_core_tdata"}, m_core_tdata, 128'(0));
    check({nm, "_s_tready"}, 128'(s_axis_tready), 128'(0));
    check({nm, "_m_tvalid"}, 128'(m_axis_tvalid), 128'(0));
    check({nm, "_m_tdata"}, m_axis_tdata, 128'(0));
    check({nm, "_m_tlast"}, 128'(m_axis_tlast), 128'(0));
    check({nm, "_busy"}, 128'(po_busy), 128'(0));
    check({nm, "_ovf"}, 128'(po_ks_overflow), 128'(0));
`ifdef AES_CTR_WRAP_GUARD_EN
    check({nm, "_wrap"}, 128'(po_ctr_wrap), 128'(0));
`endif
  endtask

  initial begin : main
    aes_blk_t iv;
    aes_blk_t d;
    rst           = 1'b1;
    pi_start      = 1'b0;
    pi_iv         = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;

    // NIST SP800-38A F.5.5 AES-256 CTR
    start_msg(NIST_IV);
    send_blk(NIST_P0, 1'b0, NIST_C0, 0);
    send_blk(NIST_P1, 1'b1, NIST_C1, 0);
    wait_drain("nist_drain");
    wait_idle("nist_idle");
    check("nist_ctr0", (ctr_log.size() > 0) ? ctr_log[0] : 'x, NIST_IV);
    check("nist_ctr1", (ctr_log.size() > 1) ? ctr_log[1] : 'x, NIST_CTR1);

    // Credit limit with no payload offered
    iv = rand128();
    start_msg(iv);
    repeat (30) @(posedge clk);
    #1;
    check("credit_hs", 128'(hs_count), 128'(DEPTH));
    check("credit_tvalid", 128'(m_core_tvalid), 128'(0));
    check("credit_ovf", 128'(po_ks_overflow), 128'(0));
    d = rand128();
    send_blk(d, 1'b1, d ^ ks_fn(iv), 0);
    wait_drain("credit_drain");
    wait_idle("credit_idle");

    // Output backpressure 1010 over 8 blocks
    mrdy_mode     = 1;
    core_rdy_mode = 1;
    run_msg("bp", rand128(), 8, 1);
    mrdy_mode     = 0;
    core_rdy_mode = 0;

    // Early tlast with a full prefetch, then clean restart
    iv = rand128();
    start_msg(iv);
    repeat (20) @(posedge clk);
    #1;
    check("early_prefetch", 128'(hs_count), 128'(DEPTH));
    d = rand128();
    send_blk(d, 1'b1, d ^ ks_fn(iv), 0);
    wait_drain("early_drain");
    wait_idle("early_idle");
    check("early_no_issue", 128'(hs_count), 128'(DEPTH));
    run_msg("restart", rand128(), 3, 0);

    // Counter wrap of the low CTR_W bits
    iv = rand128();
    iv[31:0] = 32'hffffffff;
`ifdef AES_CTR_WRAP_GUARD_EN
    start_msg(iv);
    repeat (20) @(posedge clk);
    #1;
    check("wrap_hs", 128'(hs_count), 128'(1));
    check("wrap_flag", 128'(po_ctr_wrap), 128'(1));
    check("wrap_tvalid", 128'(m_core_tvalid), 128'(0));
    d = rand128();
    send_blk(d, 1'b1, d ^ ks_fn(iv), 0);
    wait_drain("wrap_drain");
    wait_idle("wrap_idle");
`else
    run_msg("wrap", iv, 2, 0);
    check("wrap_ctr1", (ctr_log.size() > 1) ? ctr_log[1] : 'x, {iv[127:32], 32'h0});
`endif

    // Reset in the middle of a message
    iv = rand128();
    start_msg(iv);
    for (int i = 0; i < 2; i++) begin
      d = rand128();
      send_blk(d, 1'b0, d ^ ks_fn(ctr_at(iv, i)), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_sb", 128'(sb.size()), 128'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    @(posedge clk);
    #1;

    // Randomised messages with random handshakes and key-ready stalls
    core_rdy_mode = 1;
    key_rdy_mode  = 1;
    mrdy_mode     = 2;
    for (int k = 0; k < 4; k++) begin
      run_msg($sformatf("rnd%0d", k), rand128(), $urandom_range(1, 8), 2);
    end
    check("ovf_final", 128'(po_ks_overflow), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
